bp_cce_hybrid_lce_cmd_arb: RTL

- Arbitrates the single hybrid-CCE LCE command output channel (BedRock burst protocol, ready&valid) between num_req_p command sources: control/sync module, uncached pipe and coherent pipe.
- Grants one message at a time, round-robin among unmasked requesters.
- Holds the grant from header presentation until message completion, so header and data beats of different messages never interleave.
- Sits between the CCE command producers and the LCE command network.

---
 rtl/bp_cce_hybrid_lce_cmd_arb.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/bp_cce_hybrid_lce_cmd_arb.sv
// Round-robin arbiter for the hybrid CCE LCE command channel (BedRock burst, ready&valid).
// Latency: zero-cycle combinational forwarding of the winner's header; data follows one or more cycles later.
// Backpressure: downstream ready is routed only to the granted requester; grant is held until message end.
//
// Ports:
//   req_*_i / req_*_o        per-requester header, data, has_data, last, mask and ready signals
//   lce_cmd_*                muxed LCE command output channel (header + data beats)
//   grant_o                  one-hot current grant (0 when idle with no eligible requester)
//   busy_o                   a message is in progress
module bp_cce_hybrid_lce_cmd_arb #(
    parameter int num_req_p      = 3,
    parameter int header_width_p = 128,
    parameter int data_width_p   = 64
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic [num_req_p*header_width_p-1:0] req_header_i,
    input  logic [num_req_p-1:0]                req_header_v_i,
    output logic [num_req_p-1:0]                req_header_ready_and_o,
    input  logic [num_req_p-1:0]                req_has_data_i,
    input  logic [num_req_p*data_width_p-1:0]   req_data_i,
    input  logic [num_req_p-1:0]                req_data_v_i,
    output logic [num_req_p-1:0]                req_data_ready_and_o,
    input  logic [num_req_p-1:0]                req_last_i,
    input  logic [num_req_p-1:0]                req_mask_i,
    output logic [header_width_p-1:0]           lce_cmd_header_o,
    output logic                                lce_cmd_header_v_o,
    input  logic                                lce_cmd_header_ready_and_i,
    output logic                                lce_cmd_has_data_o,
    output logic [data_width_p-1:0]             lce_cmd_data_o,
    output logic                                lce_cmd_data_v_o,
    input  logic                                lce_cmd_data_ready_and_i,
    output logic                                lce_cmd_last_o,
    output logic [num_req_p-1:0]                grant_o,
    output logic                                busy_o
);

    localparam int iw_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

    typedef enum logic [1:0] {e_idle, e_hdr, e_data} state_e;

    state_e             state_q, state_d;
    logic [iw_lp-1:0]   ptr_q, ptr_d;
    logic [iw_lp-1:0]   gidx_q, gidx_d;
    logic [iw_lp-1:0]   win_idx, cand, sel_idx;
    logic               win_found, sel_act;
    logic [num_req_p-1:0] elig;

    logic [header_width_p-1:0] hdr_sel;
    logic [data_width_p-1:0]   dat_sel;
    logic                      hv_sel, hd_sel, dv_sel, last_sel;
    logic                      hdr_hs, data_hs;

    assign elig = req_header_v_i & ~req_mask_i;

    // Search upward from ptr+1, wrapping, for the first eligible requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= num_req_p; k++) begin
            cand = iw_lp'((int'(ptr_q) + k) % num_req_p);
            if (!win_found && elig[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // In idle the arbiter's choice drives the mux; once a message is open the latched index does.
    always_comb begin
        sel_act = 1'b0;
        sel_idx = '0;
        case (state_q)
            e_idle:  begin sel_act = win_found; sel_idx = win_idx; end
            default: begin sel_act = 1'b1;      sel_idx = gidx_q;  end
        endcase
    end

    always_comb begin
        hdr_sel  = '0;
        dat_sel  = '0;
        hv_sel   = 1'b0;
        hd_sel   = 1'b0;
        dv_sel   = 1'b0;
        last_sel = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            if (iw_lp'(i) == sel_idx) begin
                hdr_sel  = req_header_i[i*header_width_p +: header_width_p];
                dat_sel  = req_data_i[i*data_width_p +: data_width_p];
                hv_sel   = req_header_v_i[i];
                hd_sel   = req_has_data_i[i];
                dv_sel   = req_data_v_i[i];
                last_sel = req_last_i[i];
            end
        end
    end

    // Outputs are also gated by reset_n_i so an asserted reset silences the
    // channel even while requesters keep driving valid.
    always_comb begin
        grant_o                = '0;
        req_header_ready_and_o = '0;
        req_data_ready_and_o   = '0;
        lce_cmd_header_o       = '0;
        lce_cmd_header_v_o     = 1'b0;
        lce_cmd_has_data_o     = 1'b0;
        lce_cmd_data_o         = '0;
        lce_cmd_data_v_o       = 1'b0;
        lce_cmd_last_o         = 1'b0;
        if (reset_n_i && sel_act) begin
            grant_o[sel_idx] = 1'b1;
            if (state_q == e_data) begin
                lce_cmd_data_o                = dat_sel;
                lce_cmd_data_v_o              = dv_sel;
                lce_cmd_last_o                = last_sel;
                req_data_ready_and_o[sel_idx] = lce_cmd_data_ready_and_i;
            end else begin
                lce_cmd_header_o                = hdr_sel;
                lce_cmd_header_v_o              = hv_sel;
                lce_cmd_has_data_o              = hd_sel;
                req_header_ready_and_o[sel_idx] = lce_cmd_header_ready_and_i;
            end
        end
    end

    assign busy_o  = (state_q != e_idle);
    assign hdr_hs  = lce_cmd_header_v_o & lce_cmd_header_ready_and_i;
    assign data_hs = lce_cmd_data_v_o & lce_cmd_data_ready_and_i;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        case (state_q)
            e_idle: begin
                if (win_found) begin
                    gidx_d = win_idx;
                    if (hdr_hs) begin
                        if (lce_cmd_has_data_o) state_d = e_data;
                        else                    ptr_d   = win_idx;
                    end else begin
                        state_d = e_hdr;
                    end
                end
            end
            e_hdr: begin
                if (hdr_hs) begin
                    if (lce_cmd_has_data_o) begin
                        state_d = e_data;
                    end else begin
                        state_d = e_idle;
                        ptr_d   = gidx_q;
                    end
                end
            end
            e_data: begin
                if (data_hs && lce_cmd_last_o) begin
                    state_d = e_idle;
                    ptr_d   = gidx_q;
                end
            end
            default: state_d = e_idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_idle;
            ptr_q   <= iw_lp'(num_req_p - 1);
            gidx_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
        end
    end

endmodule
